eth_reg_init_seq: RTL and testbench

- Table-driven register initialisation sequencer for the KSZ8851-class Ethernet controller.
- Sits between the Ethernet top level and the register-access controller, ahead of the TX/RX datapath mux.
- After a power-up warm-up delay it walks an external init-table ROM, issuing write, read-modify-write and read-and-verify accesses.
- Adds retry on verify mismatch, access timeout, error reporting, and re-initialisation on request.

---
 rtl/eth_reg_init_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_eth_reg_init_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_reg_init_seq.sv
// Table-driven register initialisation sequencer for a KSZ8851-class Ethernet
// controller. After a warm-up delay it walks an external init-table ROM and
// issues write, read-modify-write and read-and-verify register accesses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WARM     | power-up delay before the first table access
// FETCH    | tbl_addr presented to the ROM
// DECODE   | ROM word valid; latch fields and pick the access type
// ISSUE    | first cycle of a request (cmd_req high, timeout count at 0)
// WAIT_ACK | request held until cmd_ack or timeout
// GAP      | idle spacing between VERIFY attempts
// NEXT     | entry finished; advance step or finish on the last slot
// DONE     | table completed, init_done held until restart
// ERROR    | sequence aborted, init_error held until restart
module eth_reg_init_seq #(
  parameter int WARM_CYCLES = 2097152,
  parameter int WARM_W      = 28,
  parameter int TBL_AW      = 5,
  parameter int MAX_RETRY   = 4,
  parameter int RETRY_GAP   = 1024,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              restart,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [41:0]       tbl_entry,
  output logic              cmd_req,
  output logic              cmd_wr,
  output logic [7:0]        cmd_offset,
  output logic              cmd_length,
  output logic [15:0]       cmd_wdata,
  input  logic              cmd_ack,
  input  logic [15:0]       rd_data,
  output logic              busy,
  output logic              init_done,
  output logic              init_error,
  output logic [TBL_AW-1:0] err_step,
  output logic [1:0]        err_code
);

  localparam int GAP_W = $clog2(RETRY_GAP + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RETRY_GAP - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_RMW    = 2'd1;
  localparam logic [1:0] OP_VERIFY = 2'd2;
  localparam logic [1:0] OP_END    = 2'd3;

  typedef enum logic [3:0] {
    S_WARM, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_ACK, S_GAP, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t             state, state_n;
  logic [WARM_W-1:0]  warm_cnt, warm_cnt_n;
  logic [TBL_AW-1:0]  step, step_n;
  logic [1:0]         op_q, op_n;
  logic [15:0]        data_q, data_n;
  logic [15:0]        mask_q, mask_n;
  logic               wr_phase, wr_phase_n;
  logic [TO_W-1:0]    tmo_cnt, tmo_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [RTY_W-1:0]   rty_cnt, rty_cnt_n;
  logic               cmd_req_n, cmd_wr_n;
  logic [7:0]         cmd_offset_n;
  logic [15:0]        cmd_wdata_n;
  logic               init_done_n, init_error_n;
  logic [TBL_AW-1:0]  err_step_n;
  logic [1:0]         err_code_n;

  logic               verify_ok;
  logic [15:0]        rmw_merge;

  assign verify_ok  = ((rd_data & mask_q) == (data_q & mask_q));
  assign rmw_merge  = (rd_data & ~mask_q) | (data_q & mask_q);
  assign tbl_addr   = step;
  assign cmd_length = 1'b1;
  assign busy       = (state != S_DONE) && (state != S_ERROR);

  // Next-state and next-register values; every register holds by default.
  always_comb begin
    state_n      = state;
    warm_cnt_n   = warm_cnt;
    step_n       = step;
    op_n         = op_q;
    data_n       = data_q;
    mask_n       = mask_q;
    wr_phase_n   = wr_phase;
    tmo_cnt_n    = tmo_cnt;
    gap_cnt_n    = gap_cnt;
    rty_cnt_n    = rty_cnt;
    cmd_req_n    = cmd_req;
    cmd_wr_n     = cmd_wr;
    cmd_offset_n = cmd_offset;
    cmd_wdata_n  = cmd_wdata;
    init_done_n  = init_done;
    init_error_n = init_error;
    err_step_n   = err_step;
    err_code_n   = err_code;

    case (state)
      S_WARM: begin
        if (warm_cnt == WARM_LAST) begin
          warm_cnt_n = '0;
          state_n    = S_FETCH;
        end else begin
          warm_cnt_n = warm_cnt + 1'b1;
        end
      end

      S_FETCH: state_n = S_DECODE;

      // ROM word is valid one cycle after the address, i.e. in this state.
      S_DECODE: begin
        op_n         = tbl_entry[41:40];
        cmd_offset_n = tbl_entry[39:32];
        data_n       = tbl_entry[31:16];
        mask_n       = tbl_entry[15:0];
        wr_phase_n   = 1'b0;
        if (tbl_entry[41:40] == OP_END) begin
          init_done_n = 1'b1;
          state_n     = S_DONE;
        end else begin
          cmd_wr_n    = (tbl_entry[41:40] == OP_WRITE);
          cmd_wdata_n = (tbl_entry[41:40] == OP_WRITE) ? tbl_entry[31:16] : 16'h0000;
          cmd_req_n   = 1'b1;
          tmo_cnt_n   = '0;
          state_n     = S_ISSUE;
        end
      end

      S_ISSUE, S_WAIT_ACK: begin
        if (cmd_ack) begin
          cmd_req_n = 1'b0;
          if (op_q == OP_RMW && !wr_phase) begin
            // read phase done: merge and reissue as the write phase
            cmd_wdata_n = rmw_merge;
            cmd_wr_n    = 1'b1;
            wr_phase_n  = 1'b1;
            cmd_req_n   = 1'b1;
            tmo_cnt_n   = '0;
            state_n     = S_ISSUE;
          end else if (op_q == OP_VERIFY && !verify_ok) begin
            if (rty_cnt < RTY_MAX) begin
              gap_cnt_n = '0;
              state_n   = S_GAP;
            end else begin
              init_error_n = 1'b1;
              err_step_n   = step;
              err_code_n   = 2'd1;
              state_n      = S_ERROR;
            end
          end else begin
            state_n = S_NEXT;
          end
        end else if (tmo_cnt == TO_LAST) begin
          cmd_req_n    = 1'b0;
          init_error_n = 1'b1;
          err_step_n   = step;
          err_code_n   = 2'd2;
          state_n      = S_ERROR;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
          state_n   = S_WAIT_ACK;
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          rty_cnt_n = rty_cnt + 1'b1;
          cmd_req_n = 1'b1;
          tmo_cnt_n = '0;
          state_n   = S_ISSUE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end

      // Last slot without an END entry finishes the table implicitly.
      S_NEXT: begin
        rty_cnt_n = '0;
        if (step == '1) begin
          init_done_n = 1'b1;
          state_n     = S_DONE;
        end else begin
          step_n  = step + 1'b1;
          state_n = S_FETCH;
        end
      end

      S_DONE, S_ERROR: begin
        if (restart) begin
          init_done_n  = 1'b0;
          init_error_n = 1'b0;
          err_step_n   = '0;
          err_code_n   = 2'd0;
          step_n       = '0;
          state_n      = S_FETCH;
        end
      end

      default: state_n = S_WARM;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state      <= S_WARM;
      warm_cnt   <= '0;
      step       <= '0;
      op_q       <= OP_WRITE;
      data_q     <= '0;
      mask_q     <= '0;
      wr_phase   <= 1'b0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      rty_cnt    <= '0;
      cmd_req    <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_offset <= '0;
      cmd_wdata  <= '0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      err_step   <= '0;
      err_code   <= 2'd0;
    end else begin
      state      <= state_n;
      warm_cnt   <= warm_cnt_n;
      step       <= step_n;
      op_q       <= op_n;
      data_q     <= data_n;
      mask_q     <= mask_n;
      wr_phase   <= wr_phase_n;
      tmo_cnt    <= tmo_cnt_n;
      gap_cnt    <= gap_cnt_n;
      rty_cnt    <= rty_cnt_n;
      cmd_req    <= cmd_req_n;
      cmd_wr     <= cmd_wr_n;
      cmd_offset <= cmd_offset_n;
      cmd_wdata  <= cmd_wdata_n;
      init_done  <= init_done_n;
      init_error <= init_error_n;
      err_step   <= err_step_n;
      err_code   <= err_code_n;
    end
  end

endmodule

// File: tb/tb_eth_reg_init_seq.sv
// Bench for eth_reg_init_seq: table ROM and access-controller models, an
// access-list model derived from the table rules, and directed scenarios.
module tb_eth_reg_init_seq;

  localparam int WARM_CYCLES = 16;
  localparam int TBL_AW      = 2;
  localparam int DEPTH       = 4;
  localparam int MAX_RETRY   = 2;
  localparam int RETRY_GAP   = 8;
  localparam int ACK_TIMEOUT = 10;
  localparam int ACK_LAT     = 2;

  logic              sysclk = 1'b0;
  logic              reset, restart;
  logic [TBL_AW-1:0] tbl_addr;
  logic [41:0]       tbl_entry;
  logic              cmd_req, cmd_wr, cmd_length, cmd_ack;
  logic [7:0]        cmd_offset;
  logic [15:0]       cmd_wdata, rd_data;
  logic              busy, init_done, init_error;
  logic [TBL_AW-1:0] err_step;
  logic [1:0]        err_code;

  eth_reg_init_seq #(
    .WARM_CYCLES(WARM_CYCLES), .WARM_W(8), .TBL_AW(TBL_AW),
    .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .sysclk(sysclk), .reset(reset), .restart(restart),
    .tbl_addr(tbl_addr), .tbl_entry(tbl_entry),
    .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_offset(cmd_offset),
    .cmd_length(cmd_length), .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack), .rd_data(rd_data),
    .busy(busy), .init_done(init_done), .init_error(init_error),
    .err_step(err_step), .err_code(err_code)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic        wr;
    logic [7:0]  off;
    logic [15:0] wdata;
    int          gap;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [41:0] rom [DEPTH];
  logic [41:0] rom_pipe;
  logic [15:0] rd_val [256];
  logic [15:0] obs_wdata [256];
  bit          ack_en, stray_req;
  exp_t        exp_q [$];
  bit          exp_done, exp_error;
  int          exp_code, exp_step;
  int          n_acc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [41:0] ent(input logic [1:0] op, input logic [7:0] off,
                                      input logic [15:0] d, input logic [15:0] m);
    return {op, off, d, m};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = {2'd3, 40'd0};
  endtask

  task automatic push_acc(input logic wr, input logic [7:0] off, input logic [15:0] wd, input int gap);
    exp_t e;
    e.wr = wr; e.off = off; e.wdata = wd; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Expected access list and final status, straight from the table rules.
  task automatic build_model(input bit acks_on);
    logic [1:0]  op;
    logic [7:0]  off;
    logic [15:0] d, m, rd;
    exp_q.delete();
    exp_done = 0; exp_error = 0; exp_code = 0; exp_step = 0;
    for (int i = 0; i < DEPTH; i++) begin
      op = rom[i][41:40]; off = rom[i][39:32]; d = rom[i][31:16]; m = rom[i][15:0];
      rd = rd_val[off];
      if (op == 2'd3) begin exp_done = 1; return; end
      if (!acks_on) begin
        push_acc(op == 2'd0, off, d, -1);
        exp_error = 1; exp_code = 2; exp_step = i;
        return;
      end
      case (op)
        2'd0: push_acc(1'b1, off, d, -1);
        2'd1: begin
          push_acc(1'b0, off, 16'h0, -1);
          push_acc(1'b1, off, (rd & ~m) | (d & m), -1);
        end
        default: begin
          if ((rd & m) == (d & m)) push_acc(1'b0, off, 16'h0, -1);
          else begin
            for (int k = 0; k <= MAX_RETRY; k++) push_acc(1'b0, off, 16'h0, (k == 0) ? -1 : RETRY_GAP);
            exp_error = 1; exp_code = 1; exp_step = i;
            return;
          end
        end
      endcase
    end
    exp_done = 1;
  endtask

  // ROM with one cycle of address-to-data latency.
  initial begin
    tbl_entry = '0; rom_pipe = '0;
    forever begin
      @(negedge sysclk);
      tbl_entry = rom_pipe;
      rom_pipe  = rom[tbl_addr];
    end
  end

  // Access controller: acks after ACK_LAT held cycles; can emit a stray ack.
  initial begin
    int lat;
    cmd_ack = 1'b0; rd_data = 16'h0; lat = 0;
    forever begin
      @(negedge sysclk);
      #2;
      if (cmd_ack) begin cmd_ack = 1'b0; lat = 0; end
      else if (reset !== 1'b1) lat = 0;
      else if (cmd_req) begin
        if (!ack_en) lat = 0;
        else if (lat == ACK_LAT) begin cmd_ack = 1'b1; rd_data = rd_val[cmd_offset]; lat = 0; end
        else lat++;
      end else begin
        lat = 0;
        if (stray_req) begin cmd_ack = 1'b1; rd_data = 16'hFFFF; stray_req = 0; end
      end
    end
  end

  // Per-cycle compare of DUT outputs against the access-list model.
  initial begin
    bit   in_acc = 0, prev_busy = 1, cur_valid = 0;
    int   idle = 0;
    exp_t cur;
    forever begin
      @(negedge sysclk);
      if (reset !== 1'b1) begin
        in_acc = 0; prev_busy = 1; idle = 0; cur_valid = 0;
      end else begin
        check("cmd_length", cmd_length, 1);
        check("busy_vs_status", busy, !(init_done || init_error));
        check("done_err_excl", init_done & init_error, 0);
        if (cmd_ack || !cmd_req) in_acc = 0;
        if (cmd_req && !in_acc) begin
          in_acc = 1; n_acc++;
          if (exp_q.size() == 0) begin
            checks++; errors++; cur_valid = 0;
            $display("FAIL extra_access offset %0h wr %0b", cmd_offset, cmd_wr);
          end else begin
            cur = exp_q.pop_front(); cur_valid = 1;
            if (cur.gap >= 0) check("retry_gap", idle, cur.gap);
          end
          if (cmd_wr) obs_wdata[cmd_offset] = cmd_wdata;
          idle = 0;
        end
        if (cmd_req && cur_valid) begin
          check("acc_wr", cmd_wr, cur.wr);
          check("acc_offset", cmd_offset, cur.off);
          if (cur.wr) check("acc_wdata", cmd_wdata, cur.wdata);
        end
        if (!cmd_req) idle++;
        if (prev_busy && !busy) begin
          check("end_done", init_done, exp_done);
          check("end_error", init_error, exp_error);
          check("end_code", err_code, exp_code);
          check("end_step", err_step, exp_step);
          check("model_drained", exp_q.size(), 0);
        end
        prev_busy = busy;
      end
    end
  end

  task automatic check_reset_state();
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_cmd_req", cmd_req, 0);
    check("rst_cmd_wr", cmd_wr, 0);
    check("rst_cmd_offset", cmd_offset, 0);
    check("rst_cmd_length", cmd_length, 1);
    check("rst_cmd_wdata", cmd_wdata, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_error", init_error, 0);
    check("rst_err_step", err_step, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 1);
  endtask

  task automatic wait_req(input int lim, output int n);
    n = 0;
    while (n < lim) begin
      @(negedge sysclk);
      n++;
      if (cmd_req) return;
    end
    checks++; errors++;
    $display("FAIL wait_req timeout after %0d cycles", lim);
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    while (busy && t < lim) begin @(negedge sysclk); t++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle busy still %0b after %0d cycles", busy, lim);
    end
  endtask

  task automatic restart_seq(output int lat);
    @(negedge sysclk); restart = 1'b1;
    @(negedge sysclk); restart = 1'b0;
    lat = 1;
    while (!cmd_req && lat < 50) begin @(negedge sysclk); lat++; end
  endtask

  initial begin
    int n, a0, hi;
    reset = 1'b0; restart = 1'b0; ack_en = 1; stray_req = 0;
    for (int i = 0; i < 256; i++) begin rd_val[i] = 16'h0; obs_wdata[i] = 16'h0; end

    // Warm-up timing, single write then END.
    clear_rom();
    rom[0] = ent(2'd0, 8'h10, 16'h89AB, 16'hFFFF);
    build_model(1);
    repeat (3) @(negedge sysclk);
    check_reset_state();
    stray_req = 1;
    reset = 1'b1;
    wait_req(100, n);
    check("first_req_cycle", n, WARM_CYCLES + 2);
    wait_idle(500);
    check("a_done", init_done, 1);
    check("a_wdata_10", obs_wdata[8'h10], 16'h89AB);

    // VERIFY with masked match, then a write.
    clear_rom();
    rom[0] = ent(2'd2, 8'hC0, 16'h0870, 16'h0FF0);
    rom[1] = ent(2'd0, 8'h22, 16'h1234, 16'hFFFF);
    rd_val[8'hC0] = 16'h8872;
    build_model(1);
    a0 = n_acc;
    restart_seq(n);
    check("b_restart_lat", n, 3);
    wait_idle(500);
    check("b_done", init_done, 1);
    check("b_accesses", n_acc - a0, 2);

    // Read-modify-write merges.
    clear_rom();
    rom[0] = ent(2'd1, 8'h70, 16'h0001, 16'h0001);
    rom[1] = ent(2'd1, 8'hF6, 16'h2000, 16'h2020);
    rd_val[8'h70] = 16'h01EE;
    rd_val[8'hF6] = 16'h00FF;
    build_model(1);
    restart_seq(n);
    wait_idle(500);
    check("c_done", init_done, 1);
    check("c_rmw_70", obs_wdata[8'h70], 16'h01EF);
    check("c_rmw_f6", obs_wdata[8'hF6], 16'h20DF);

    // VERIFY that never matches: retries, then error code 1.
    clear_rom();
    rom[0] = ent(2'd2, 8'h30, 16'h1234, 16'hFFFF);
    rd_val[8'h30] = 16'h0000;
    build_model(1);
    a0 = n_acc;
    stray_req = 1;
    restart_seq(n);
    wait_idle(500);
    check("d_error", init_error, 1);
    check("d_done", init_done, 0);
    check("d_code", err_code, 1);
    check("d_step", err_step, 0);
    check("d_reads", n_acc - a0, MAX_RETRY + 1);

    // Ack timeout, then restart without warm-up once acks resume.
    clear_rom();
    rom[0] = ent(2'd0, 8'h40, 16'h5555, 16'hFFFF);
    rom[1] = ent(2'd0, 8'h41, 16'h6666, 16'hFFFF);
    ack_en = 0;
    build_model(0);
    restart_seq(n);
    check("e_restart_lat", n, 3);
    hi = 1;
    for (int k = 0; k < 50 && cmd_req; k++) begin
      @(negedge sysclk);
      if (cmd_req) hi++;
    end
    check("e_req_high_cycles", hi, ACK_TIMEOUT);
    wait_idle(100);
    check("e_code", err_code, 2);
    check("e_error", init_error, 1);
    ack_en = 1;
    build_model(1);
    restart_seq(n);
    check("e_rerun_lat", n, 3);
    wait_idle(500);
    check("e_rerun_done", init_done, 1);
    check("e_rerun_code", err_code, 0);

    // Table without END: all four slots, then done.
    clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = ent(2'd0, 8'h50 + 8'(i), 16'h1000 + 16'(i), 16'hFFFF);
    build_model(1);
    a0 = n_acc;
    restart_seq(n);
    wait_idle(500);
    check("f_done", init_done, 1);
    check("f_accesses", n_acc - a0, DEPTH);
    check("f_last_wdata", obs_wdata[8'h53], 16'h1003);

    // Reset in the middle of an access, then full warm-up again.
    ack_en = 0;
    build_model(1);
    restart_seq(n);
    repeat (2) @(negedge sysclk);
    check("g_req_held", cmd_req, 1);
    reset = 1'b0;
    @(negedge sysclk);
    check_reset_state();
    ack_en = 1;
    build_model(1);
    a0 = n_acc;
    reset = 1'b1;
    wait_req(100, n);
    check("g_first_req_cycle", n, WARM_CYCLES + 2);
    wait_idle(500);
    check("g_done", init_done, 1);
    check("g_accesses", n_acc - a0, DEPTH);

    repeat (3) @(negedge sysclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
